axi_rd_bram_loader: RTL and testbench

Read-DMA stage that feeds the input BRAM of the bf16 multiply-tree datapath. On a start command it issues AXI4 INCR read bursts to external memory for a given number of 256-bit beats. Each beat is split into two 128-bit words, low half first, and written to consecutive input-BRAM addresses. It reports busy/done/error to the controller. One burst is outstanding at a time.

---
 rtl/axi_rd_bram_loader.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axi_rd_bram_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_bram_loader.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_bram_loader
// Purpose  : Read-DMA stage feeding the input BRAM of the bf16 multiply-tree
//            datapath. On a start command it fetches total_beats 256-bit
//            beats from external memory with AXI4 INCR bursts (one burst
//            outstanding at a time), splits every beat into two 128-bit
//            words (low half first) and writes them to consecutive BRAM
//            addresses starting at bram_base.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start               : command strobe, only sampled while idle
//   src_addr            : byte address of first beat (burst-size aligned)
//   total_beats         : number of 256-bit beats to fetch
//   bram_base           : first BRAM word address
//   busy / done / err   : status; done is a one-cycle pulse, err is sticky
//                         until the next accepted start
//   M_AXI_AR* / M_AXI_R*: AXI4 read address / read data channels
//   bram_we/waddr/wdata : BRAM write port, one 128-bit word per cycle
// ============================================================================
module axi_rd_bram_loader #(
  parameter int M_AXI_ID_WIDTH   = 4,
  parameter int M_AXI_DATA_WIDTH = 256,
  parameter int BRAM_DW          = 128,
  parameter int BRAM_AW          = 11,
  parameter int MAX_BURST        = 16,
  parameter int LEN_W            = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [31:0]                 src_addr,
  input  logic [LEN_W-1:0]            total_beats,
  input  logic [BRAM_AW-1:0]          bram_base,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [31:0]                 M_AXI_ARADDR,
  output logic [7:0]                  M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARLOCK,
  output logic [3:0]                  M_AXI_ARCACHE,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic [3:0]                  M_AXI_ARQOS,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  output logic                        bram_we,
  output logic [BRAM_AW-1:0]          bram_waddr,
  output logic [BRAM_DW-1:0]          bram_wdata
);

  // Low address bits that must be zero; a burst-size aligned start can never
  // make a burst cross a 4KB boundary.
  localparam int               c_ALIGN_BITS = $clog2(MAX_BURST * 32);
  localparam int               c_HI_W       = M_AXI_DATA_WIDTH - BRAM_DW;
  localparam logic [LEN_W-1:0] c_MAX_BURST  = LEN_W'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_AR    = 3'd2,
    S_RDATA = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t               state_q;
  logic [LEN_W-1:0]     beats_q;       // latched beat count of the command
  logic [LEN_W-1:0]     remaining_q;   // beats not yet requested
  logic [7:0]           beat_cnt_q;    // beats left in current burst, minus one
  logic [31:0]          araddr_q;
  logic [7:0]           arlen_q;
  logic                 arvalid_q;
  logic [BRAM_AW-1:0]   wptr_q;        // next BRAM address to be written
  logic [BRAM_AW-1:0]   bram_waddr_q;
  logic [BRAM_DW-1:0]   bram_wdata_q;
  logic                 bram_we_q;
  logic [c_HI_W-1:0]    hold_hi_q;     // upper half of the last accepted beat
  // Set while the low half is on the BRAM port and the upper half is still
  // waiting in hold_hi_q. When clear, the hold register is free for a new
  // beat at the end of this cycle (it is either empty or emitting its upper
  // half right now).
  logic                 hold_lo_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic                 rready_d;
  logic                 r_hs_d;
  logic                 last_beat_d;
  logic [31:0]          araddr_d;
  logic [LEN_W-1:0]     remaining_d;

  // Beats-minus-one of the next burst given the beats still to request.
  function automatic logic [7:0] burst_len_m1(input logic [LEN_W-1:0] rem);
    if (rem >= c_MAX_BURST) begin
      return 8'(MAX_BURST - 1);
    end
    return 8'(rem - LEN_W'(1));
  endfunction

  assign rready_d    = (state_q == S_RDATA) && !hold_lo_q;
  assign r_hs_d      = M_AXI_RVALID && rready_d;
  assign last_beat_d = (beat_cnt_q == 8'd0);
  assign araddr_d    = araddr_q + ((32'(arlen_q) + 32'd1) << 5);
  assign remaining_d = remaining_q - (LEN_W'(arlen_q) + LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beats_q      <= '0;
      remaining_q  <= '0;
      beat_cnt_q   <= 8'd0;
      araddr_q     <= 32'd0;
      arlen_q      <= 8'd0;
      arvalid_q    <= 1'b0;
      wptr_q       <= '0;
      bram_waddr_q <= '0;
      bram_wdata_q <= '0;
      bram_we_q    <= 1'b0;
      hold_hi_q    <= '0;
      hold_lo_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      bram_we_q <= 1'b0;
      hold_lo_q <= 1'b0;

      // Width split: a beat accepted in cycle t is written low half at t+1
      // and upper half at t+2. Acceptance is blocked only while the low half
      // is being emitted, giving one beat every two cycles.
      if (hold_lo_q) begin
        bram_we_q    <= 1'b1;
        bram_wdata_q <= hold_hi_q;
        bram_waddr_q <= wptr_q;
        wptr_q       <= wptr_q + BRAM_AW'(1);
      end else if (r_hs_d) begin
        bram_we_q    <= 1'b1;
        bram_wdata_q <= M_AXI_RDATA[BRAM_DW-1:0];
        hold_hi_q    <= M_AXI_RDATA[M_AXI_DATA_WIDTH-1:BRAM_DW];
        hold_lo_q    <= 1'b1;
        bram_waddr_q <= wptr_q;
        wptr_q       <= wptr_q + BRAM_AW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            araddr_q <= src_addr;
            beats_q  <= total_beats;
            wptr_q   <= bram_base;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (araddr_q[c_ALIGN_BITS-1:0] != '0) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else if (beats_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            remaining_q <= beats_q;
            arlen_q     <= burst_len_m1(beats_q);
            arvalid_q   <= 1'b1;
            state_q     <= S_AR;
          end
        end

        // ARADDR/ARLEN only change on the handshake, so they stay stable
        // for as long as the slave stalls.
        S_AR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q   <= 1'b0;
            araddr_q    <= araddr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= arlen_q;
            state_q     <= S_RDATA;
          end
        end

        // The local beat counter decides where a burst ends; RLAST is only
        // cross-checked against it.
        S_RDATA: begin
          if (r_hs_d) begin
            if (M_AXI_RRESP != 2'b00) begin
              err_q <= 1'b1;
            end
            if (M_AXI_RLAST != last_beat_d) begin
              err_q <= 1'b1;
            end
            if (last_beat_d) begin
              if (remaining_q != '0) begin
                arlen_q   <= burst_len_m1(remaining_q);
                arvalid_q <= 1'b1;
                state_q   <= S_AR;
              end else begin
                state_q <= S_DRAIN;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q - 8'd1;
            end
          end
        end

        // Leave once the upper half of the final beat is on the BRAM port,
        // so done lands the cycle after the last write.
        S_DRAIN: begin
          if (!hold_lo_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Read ID is not checked: only one burst is ever outstanding.
  logic w_unused_rid;
  assign w_unused_rid = ^M_AXI_RID;

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARSIZE  = 3'b101;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0010;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_d;
  assign bram_we       = bram_we_q;
  assign bram_waddr    = bram_waddr_q;
  assign bram_wdata    = bram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_bram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi_rd_bram_loader
// Purpose  : Self-checking bench for axi_rd_bram_loader. A randomized AXI
//            read slave serves beats whose content is a function of their
//            address; the expected bursts and BRAM writes of every job are
//            computed from the command with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_bram_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  src_addr;
  logic [15:0]  total_beats;
  logic [10:0]  bram_base;
  logic         busy, done, err;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic [3:0]   arqos;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;
  logic         bram_we;
  logic [10:0]  bram_waddr;
  logic [127:0] bram_wdata;

  always #5 clk = ~clk;

  axi_rd_bram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .total_beats(total_beats), .bram_base(bram_base),
    .busy(busy), .done(done), .err(err),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
    .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [10:0] a; logic [127:0] d; } wr_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mkdata(input logic [31:0] a);
    return {a ^ 32'hA5A50000, a + 32'd1, ~a, a * 32'd3,
            a ^ 32'h12345678, a + 32'h1111, {a[15:0], a[31:16]}, a * 32'd7};
  endfunction

  // Slave / monitor state
  int          cyc = 0;
  logic [31:0] beat_q[$];
  logic        last_q[$];
  ar_t         ar_log[$];
  wr_t         wr_log[$];
  int          first_ar_cyc, last_wr_cyc;
  int          done_cnt, done_cyc;
  logic        done_err, done_busy;
  int          viol_stable, viol_rready, viol_outst;
  int          ar_delay = 0, rv_pct = 100;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        drop_rlast = 1'b0;
  int          ar_wait;
  logic        prev_rhs, prev_ar_wait;
  logic [31:0] prev_araddr;
  logic [7:0]  prev_arlen;

  // AXI read slave and protocol monitor; everything is decided at negedge
  // for the handshake at the following posedge.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 4'd0;
    ar_wait = 0; prev_rhs = 1'b0; prev_ar_wait = 1'b0; prev_araddr = 32'd0; prev_arlen = 8'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        beat_q.delete(); last_q.delete();
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        ar_wait = 0; prev_rhs = 1'b0; prev_ar_wait = 1'b0;
      end else begin
        if (bram_we) begin
          wr_log.push_back('{bram_waddr, bram_wdata});
          last_wr_cyc = cyc;
        end
        if (done) begin
          done_cnt++; done_cyc = cyc; done_err = err; done_busy = busy;
        end
        if (prev_ar_wait && (!arvalid || araddr !== prev_araddr || arlen !== prev_arlen)) viol_stable++;
        if (prev_rhs && rready) viol_rready++;
        if (arvalid && beat_q.size() != 0) viol_outst++;
        // R channel: an unaccepted beat stays put
        if (!(rvalid && !prev_rhs)) begin
          rvalid = 1'b0;
          if (beat_q.size() != 0 && int'($urandom_range(99)) < rv_pct) begin
            rvalid = 1'b1;
            rdata  = mkdata(beat_q[0]);
            rresp  = (beat_q[0] == err_addr) ? 2'b10 : 2'b00;
            rlast  = last_q[0];
            if (rlast && drop_rlast) begin
              rlast = 1'b0; drop_rlast = 1'b0;
            end
          end
        end
        prev_rhs = rvalid && rready;
        if (prev_rhs) begin
          void'(beat_q.pop_front()); void'(last_q.pop_front());
        end
        // AR channel
        if (arvalid) begin
          ar_wait++;
          arready = (ar_wait > ar_delay);
        end else begin
          arready = 1'b0;
        end
        prev_ar_wait = arvalid && !arready;
        prev_araddr  = araddr;
        prev_arlen   = arlen;
        if (arvalid && arready) begin
          if (ar_log.size() == 0) first_ar_cyc = cyc;
          ar_log.push_back('{araddr, arlen});
          for (int i = 0; i <= int'(arlen); i++) begin
            beat_q.push_back(araddr + 32'(i * 32));
            last_q.push_back(i == int'(arlen));
          end
          ar_wait = 0;
        end
      end
    end
  end

  task automatic run_job(input string nm, input logic [31:0] s, input int n, input logic [10:0] b,
                         input int ard, input int rvp, input logic [31:0] ea, input logic dr,
                         input logic poke);
    int k, bad, rem, l;
    logic tmo, exp_err, aligned;
    logic [31:0] a;
    ar_t ear[$];
    wr_t ewr[$];
    logic [255:0] d;
    ar_log.delete(); wr_log.delete();
    done_cnt = 0; viol_stable = 0; viol_rready = 0; viol_outst = 0;
    ar_delay = ard; rv_pct = rvp; err_addr = ea; drop_rlast = dr;
    first_ar_cyc = -1; last_wr_cyc = -1;
    @(negedge clk); #1;
    start = 1'b1; src_addr = s; total_beats = 16'(n); bram_base = b; k = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    check({nm, ":busy_after_start"}, 64'(busy), 64'd1);
    check({nm, ":err_cleared"}, 64'(err), 64'd0);
    if (poke) begin
      repeat (4) @(negedge clk);
      #1 start = 1'b1; src_addr = 32'h1020; total_beats = 16'd99; bram_base = 11'd5;
      @(negedge clk); #1 start = 1'b0;
    end
    tmo = 1'b1;
    for (int t = 0; t < 8000; t++) begin
      if (done_cnt != 0) begin tmo = 1'b0; break; end
      @(negedge clk); #1;
    end
    check({nm, ":timeout"}, 64'(tmo), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    // Reference model
    aligned = (s[8:0] == 9'd0);
    exp_err = !aligned;
    if (aligned) begin
      rem = n; a = s;
      while (rem > 0) begin
        l = (rem > 16) ? 16 : rem;
        ear.push_back('{a, 8'(l - 1)});
        a = a + 32'(l * 32); rem = rem - l;
      end
      for (int i = 0; i < n; i++) begin
        d = mkdata(s + 32'(i * 32));
        ewr.push_back('{11'(int'(b) + 2 * i), d[127:0]});
        ewr.push_back('{11'(int'(b) + 2 * i + 1), d[255:128]});
        if (s + 32'(i * 32) == ea) exp_err = 1'b1;
      end
      if (dr && n > 0) exp_err = 1'b1;
    end
    check({nm, ":done_count"}, 64'(done_cnt), 64'd1);
    check({nm, ":err_at_done"}, 64'(done_err), 64'(exp_err));
    check({nm, ":busy_at_done"}, 64'(done_busy), 64'd0);
    check({nm, ":ar_count"}, 64'(ar_log.size()), 64'(ear.size()));
    bad = 0;
    for (int i = 0; i < ar_log.size() && i < ear.size(); i++) if (ar_log[i] != ear[i]) bad++;
    check({nm, ":ar_content_bad"}, 64'(bad), 64'd0);
    check({nm, ":wr_count"}, 64'(wr_log.size()), 64'(ewr.size()));
    bad = 0;
    for (int i = 0; i < wr_log.size() && i < ewr.size(); i++) if (wr_log[i] != ewr[i]) bad++;
    check({nm, ":wr_content_bad"}, 64'(bad), 64'd0);
    check({nm, ":ar_stable_viol"}, 64'(viol_stable), 64'd0);
    check({nm, ":rready_full_viol"}, 64'(viol_rready), 64'd0);
    check({nm, ":ar_outstanding_viol"}, 64'(viol_outst), 64'd0);
    if (ewr.size() == 0) check({nm, ":done_latency"}, 64'(done_cyc - k), 64'd2);
    else check({nm, ":done_after_last_wr"}, 64'(done_cyc - last_wr_cyc), 64'd1);
    if (ard == 0 && ear.size() != 0) check({nm, ":ar_latency"}, 64'(first_ar_cyc - k), 64'd2);
  endtask

  initial begin
    logic [31:0] s, ea;
    int n;
    rst_n = 1'b1; start = 1'b0; src_addr = 32'd0; total_beats = 16'd0; bram_base = 11'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst:ctrl", 64'({busy, done, err, arvalid, rready, bram_we}), 64'd0);
    check("rst:araddr", 64'(araddr), 64'd0);
    check("rst:arlen", 64'(arlen), 64'd0);
    check("rst:waddr", 64'(bram_waddr), 64'd0);
    check("rst:wdata", 64'(|bram_wdata), 64'd0);
    check("const_ar_fields", 64'({arid, arsize, arburst, arlock, arcache, arprot, arqos}),
          64'({4'd0, 3'b101, 2'b01, 1'b0, 4'b0010, 3'd0, 4'd0}));
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    run_job("basic4",   32'h1000, 4,  11'd0,    0, 100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_job("multi40",  32'h0,    40, 11'd0,    0, 100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_job("wrap",     32'h2000, 2,  11'd2046, 0, 100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_job("stall",    32'h4000, 20, 11'd100,  5, 50,  32'hFFFF_FFFF, 1'b0, 1'b0);
    run_job("misalign", 32'h1020, 3,  11'd0,    0, 100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_job("rresp",    32'h0600, 5,  11'd10,   0, 100, 32'h0640,      1'b0, 1'b0);
    run_job("zero",     32'h0800, 0,  11'd0,    0, 100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_job("norlast",  32'h3000, 18, 11'd500,  1, 80,  32'hFFFF_FFFF, 1'b1, 1'b0);
    run_job("busypoke", 32'h5000, 30, 11'd7,    0, 70,  32'hFFFF_FFFF, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      s  = $urandom & 32'h0FFF_FE00;
      n  = int'($urandom_range(1, 50));
      ea = ($urandom_range(1) == 1) ? s + 32'(int'($urandom_range(0, n - 1)) * 32) : 32'hFFFF_FFFF;
      run_job("rand", s, n, 11'($urandom), int'($urandom_range(0, 6)),
              int'($urandom_range(30, 100)), ea, 1'b0, 1'b0);
    end

    // Reset in the middle of a transfer
    ar_delay = 0; rv_pct = 100; err_addr = 32'hFFFF_FFFF; drop_rlast = 1'b0;
    @(negedge clk); #1 start = 1'b1; src_addr = 32'h8000; total_beats = 16'd30; bram_base = 11'd0;
    @(negedge clk); #1 start = 1'b0;
    repeat (12) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_abort:ctrl", 64'({busy, done, err, arvalid, rready, bram_we}), 64'd0);
    check("rst_abort:araddr", 64'(araddr), 64'd0);
    check("rst_abort:arlen", 64'(arlen), 64'd0);
    check("rst_abort:waddr", 64'(bram_waddr), 64'd0);
    check("rst_abort:wdata", 64'(|bram_wdata), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_job("after_rst", 32'h9000, 6, 11'd20, 0, 100, 32'hFFFF_FFFF, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
